alu_mem_stage: RTL and testbench
================================

Name: alu_mem_stage

Overview:
- Execute/memory datapath slice of the single-cycle MIPS core.
- Contains three parts: the ALU control decoder (ALUOp + funct -> 4-bit ALU operation and jump-register flag), the 32-bit ALU with zero flag and shamt shifts, and a word-organised data memory.
- Sits between the register file / ALUSrc mux and the MemtoReg writeback mux.

Parameters:
- MEM_WORDS, 64, number of 32-bit data-memory words (power of two).
- ADDR_BITS, 6, log2(MEM_WORDS); word-index width.

Ports:
- clk  in  1  rising-edge clock for memory writes
- rst  in  1  asynchronous active-high reset; clears data memory
- alu_op  in  3  ALUOp from main control unit
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- src_a  in  32  ALU operand A (ReadData1)
- src_b  in  32  ALU operand B (ALUSrc mux output)
- store_data  in  32  memory write data (ReadData2)
- mem_read  in  1  memory read enable
- mem_write  in  1  memory write enable
- alu_control  out  4  decoded ALU operation
- jump_reg  out  1  high for R-type jr
- alu_result  out  32  ALU result; also the memory byte address
- zero  out  1  high when alu_result == 0
- read_data  out  32  memory read data

Behaviour:
- ALU control decoding is combinational.
- alu_op encodings:
  - 000 ADD (lw/sw/addi)
  - 001 SUB (beq)
  - 010 R-type, decoded from funct
  - 011 AND (andi)
  - 100 OR (ori)
  - 101 SLT (slti)
  - 110 LUI
  - 111 -> control 1111
- R-type funct decode:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT
  - 000000 SLL, 000010 SRL
  - 001000 jr: jump_reg=1, control=ADD
  - any other funct -> 1111
- jump_reg is 1 only when alu_op=010 and funct=001000; otherwise 0.
- alu_control codes and results:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 ADD: A+B
  - 0110 SUB: A-B
  - 0111 SLT: signed A<B gives 1, else 0
  - 1100 NOR: ~(A|B)
  - 1000 SLL: B<<shamt
  - 1001 SRL: B>>shamt, logical
  - 1010 LUI: {B[15:0],16'h0}
  - 1111 and any undefined code: result 0
- ALU arithmetic is modulo 2^32; no overflow flag, no trap.
- zero is combinational from the final result.
- Shifts use the shamt port, never src_a.
- The ALU path is fully combinational and independent of clk/rst.
- Memory index = alu_result[ADDR_BITS+1:2]. Bits [1:0] are ignored (no misalignment fault). Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Memory write: on clk rising edge when mem_write=1 and rst=0, mem[index] <= store_data.
- Memory read: combinational. read_data = mem[index] when mem_read=1, else 32'h0.
- mem_read and mem_write together: read_data shows the old contents until the edge, then the new value.
- Reset: rst=1 asynchronously clears all memory words to 0 and blocks writes while asserted. A reset arriving mid-operation discards any pending write; read_data then returns 0.
- No other state exists; no output has latency beyond combinational, except the memory write (one edge).

Test Plan:
- alu_op=010, funct=100000, A=7, B=5 -> control=0010, result=12, zero=0; funct=100010, A=B=9 -> control=0110, result=0, zero=1.
- alu_op=010: funct=101010, A=32'hFFFFFFFF, B=1 -> result=1. funct=000000, B=1, shamt=31 -> 32'h80000000. funct=000010, B=32'h80000000, shamt=4 -> 32'h08000000. funct=100111, A=0, B=0 -> 32'hFFFFFFFF.
- alu_op=010, funct=001000 -> jump_reg=1, control=0010; alu_op=000, funct=001000 -> jump_reg=0.
- alu_op=110, B=32'h00001234 -> result 32'h12340000. alu_op=111 -> result 0, zero=1. alu_op=010, funct=111111 -> control 1111.
- sw: A=8, B=4 (ADD, address 12), store_data=32'hDEADBEEF, mem_write pulsed one edge. Then lw at the same address -> read_data=32'hDEADBEEF. Address 12+MEM_WORDS*4 aliases and returns the same word. mem_read=0 -> read_data=0.
- Write a word, assert rst between edges -> read of that address returns 0 immediately. A write edge while rst=1 leaves the word 0.

Source files
------------

// File: rtl/alu_mem_stage.sv
// Execute/memory slice of the single-cycle MIPS core: ALU control decode,
// 32-bit ALU with zero flag, and a word-organised data memory.
module alu_mem_stage #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [3:0]  alu_control,
  output logic        jump_reg,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] read_data
);

  typedef enum logic [3:0] {
    CTL_AND = 4'b0000,
    CTL_OR  = 4'b0001,
    CTL_ADD = 4'b0010,
    CTL_SUB = 4'b0110,
    CTL_SLT = 4'b0111,
    CTL_SLL = 4'b1000,
    CTL_SRL = 4'b1001,
    CTL_LUI = 4'b1010,
    CTL_NOR = 4'b1100,
    CTL_NOP = 4'b1111
  } alu_ctl_e;

  alu_ctl_e               w_ctl;
  logic                   w_jr;
  logic [31:0]            w_result;
  logic [ADDR_BITS-1:0]   w_idx;
  logic [31:0]            r_mem [MEM_WORDS];

  // Decode ALUOp (and funct for R-type) into the ALU operation and jr flag.
  always_comb begin
    w_ctl = CTL_NOP;
    w_jr  = 1'b0;
    unique case (alu_op)
      3'b000: w_ctl = CTL_ADD;
      3'b001: w_ctl = CTL_SUB;
      3'b010: begin
        case (funct)
          6'b100000: w_ctl = CTL_ADD;
          6'b100010: w_ctl = CTL_SUB;
          6'b100100: w_ctl = CTL_AND;
          6'b100101: w_ctl = CTL_OR;
          6'b100111: w_ctl = CTL_NOR;
          6'b101010: w_ctl = CTL_SLT;
          6'b000000: w_ctl = CTL_SLL;
          6'b000010: w_ctl = CTL_SRL;
          6'b001000: begin
            w_ctl = CTL_ADD;
            w_jr  = 1'b1;
          end
          default:   w_ctl = CTL_NOP;
        endcase
      end
      3'b011: w_ctl = CTL_AND;
      3'b100: w_ctl = CTL_OR;
      3'b101: w_ctl = CTL_SLT;
      3'b110: w_ctl = CTL_LUI;
      3'b111: w_ctl = CTL_NOP;
      default: w_ctl = CTL_NOP;
    endcase
  end

  // ALU datapath; shifts take their distance from shamt, never from src_a.
  always_comb begin
    w_result = '0;
    case (w_ctl)
      CTL_AND: w_result = src_a & src_b;
      CTL_OR:  w_result = src_a | src_b;
      CTL_ADD: w_result = src_a + src_b;
      CTL_SUB: w_result = src_a - src_b;
      CTL_SLT: w_result = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
      CTL_NOR: w_result = ~(src_a | src_b);
      CTL_SLL: w_result = src_b << shamt;
      CTL_SRL: w_result = src_b >> shamt;
      CTL_LUI: w_result = {src_b[15:0], 16'h0000};
      default: w_result = '0;
    endcase
  end

  // Word index: byte-offset bits and bits above the memory size are ignored.
  assign w_idx = w_result[ADDR_BITS+1:2];

  // Data memory write port; reset clears every word and blocks writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (mem_write) begin
      r_mem[w_idx] <= store_data;
    end
  end

  assign alu_control = w_ctl;
  assign jump_reg    = w_jr;
  assign alu_result  = w_result;
  assign zero        = (w_result == '0);
  assign read_data   = mem_read ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Self-checking bench for alu_mem_stage using an expected-value queue.
module tb_alu_mem_stage;

  localparam int unsigned MEM_WORDS = 64;
  localparam int unsigned ADDR_BITS = 6;

  logic        clk;
  logic        rst;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  alu_control;
  logic        jump_reg;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] read_data;

  alu_mem_stage #(.MEM_WORDS(MEM_WORDS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .src_a(src_a), .src_b(src_b), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .alu_control(alu_control), .jump_reg(jump_reg), .alu_result(alu_result),
    .zero(zero), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {K_RES, K_ZERO, K_CTL, K_JR, K_RD} kind_e;
  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [MEM_WORDS];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input kind_e k, input string tag, input logic [31:0] exp);
    exp_t e;
    e.kind = k;
    e.tag  = tag;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RES:   obs = alu_result;
        K_ZERO:  obs = {31'b0, zero};
        K_CTL:   obs = {28'b0, alu_control};
        K_JR:    obs = {31'b0, jump_reg};
        default: obs = read_data;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ectl, input logic ejr, input logic [31:0] eres);
    @(negedge clk);
    alu_op = op; funct = fn; shamt = sh; src_a = a; src_b = b;
    push(K_CTL,  {tag, ".ctl"},  {28'b0, ectl});
    push(K_JR,   {tag, ".jr"},   {31'b0, ejr});
    push(K_RES,  {tag, ".res"},  eres);
    push(K_ZERO, {tag, ".zero"}, {31'b0, (eres == 32'h0)});
    drain();
  endtask

  // Address via ADD (alu_op=000) and read through the reference memory.
  task automatic mem_rd(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic rd_en);
    logic [31:0] addr;
    logic [ADDR_BITS-1:0] idx;
    @(negedge clk);
    alu_op = 3'b000; src_a = a; src_b = b; mem_read = rd_en; mem_write = 1'b0;
    addr = a + b;
    idx  = addr[ADDR_BITS+1:2];
    push(K_RES, {tag, ".addr"}, addr);
    push(K_RD,  {tag, ".rd"},   rd_en ? mdl[idx] : 32'h0);
    drain();
  endtask

  // One-edge store; read_data shows old contents before the edge, new after.
  task automatic mem_wr(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d);
    logic [31:0] addr;
    logic [ADDR_BITS-1:0] idx;
    @(negedge clk);
    alu_op = 3'b000; src_a = a; src_b = b; store_data = d;
    mem_read = 1'b1; mem_write = 1'b1;
    addr = a + b;
    idx  = addr[ADDR_BITS+1:2];
    push(K_RD, {tag, ".old"}, mdl[idx]);
    drain();
    @(posedge clk);
    if (!rst) mdl[idx] = d;
    push(K_RD, {tag, ".new"}, mdl[idx]);
    drain();
    mem_write = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    foreach (mdl[i]) mdl[i] = 32'h0;
    rst = 1'b1; alu_op = 3'b000; funct = '0; shamt = '0;
    src_a = 32'd12; src_b = '0; store_data = '0; mem_read = 1'b1; mem_write = 1'b0;
    #2;
    push(K_RD, "reset.rd", 32'h0);
    push(K_RES, "reset.res", 32'd12);
    drain();
    @(negedge clk);
    rst = 1'b0;

    alu_vec("add",    3'b010, 6'b100000, 5'd0,  32'd7,        32'd5,        4'b0010, 1'b0, 32'd12);
    alu_vec("sub0",   3'b010, 6'b100010, 5'd0,  32'd9,        32'd9,        4'b0110, 1'b0, 32'd0);
    alu_vec("slt_n",  3'b010, 6'b101010, 5'd0,  32'hFFFFFFFF, 32'd1,        4'b0111, 1'b0, 32'd1);
    alu_vec("slt_p",  3'b010, 6'b101010, 5'd0,  32'd1,        32'hFFFFFFFF, 4'b0111, 1'b0, 32'd0);
    alu_vec("sll31",  3'b010, 6'b000000, 5'd31, 32'd0,        32'd1,        4'b1000, 1'b0, 32'h80000000);
    alu_vec("sll_a",  3'b010, 6'b000000, 5'd1,  32'd3,        32'd1,        4'b1000, 1'b0, 32'd2);
    alu_vec("srl4",   3'b010, 6'b000010, 5'd4,  32'd0,        32'h80000000, 4'b1001, 1'b0, 32'h08000000);
    alu_vec("nor",    3'b010, 6'b100111, 5'd0,  32'd0,        32'd0,        4'b1100, 1'b0, 32'hFFFFFFFF);
    alu_vec("and_r",  3'b010, 6'b100100, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 1'b0, 32'hF000F000);
    alu_vec("or_r",   3'b010, 6'b100101, 5'd0,  32'hF0F00000, 32'h0000000F, 4'b0001, 1'b0, 32'hF0F0000F);
    alu_vec("jr",     3'b010, 6'b001000, 5'd0,  32'd100,      32'd4,        4'b0010, 1'b1, 32'd104);
    alu_vec("nojr",   3'b000, 6'b001000, 5'd0,  32'd3,        32'd4,        4'b0010, 1'b0, 32'd7);
    alu_vec("lui",    3'b110, 6'b000000, 5'd0,  32'd0,        32'h00001234, 4'b1010, 1'b0, 32'h12340000);
    alu_vec("op111",  3'b111, 6'b100000, 5'd0,  32'd5,        32'd6,        4'b1111, 1'b0, 32'd0);
    alu_vec("badfn",  3'b010, 6'b111111, 5'd0,  32'd5,        32'd6,        4'b1111, 1'b0, 32'd0);
    alu_vec("beq",    3'b001, 6'b000000, 5'd0,  32'd5,        32'd7,        4'b0110, 1'b0, 32'hFFFFFFFE);
    alu_vec("andi",   3'b011, 6'b000000, 5'd0,  32'h0000F0F0, 32'h0000FF00, 4'b0000, 1'b0, 32'h0000F000);
    alu_vec("ori",    3'b100, 6'b000000, 5'd0,  32'h0000F0F0, 32'h00000F0F, 4'b0001, 1'b0, 32'h0000FFFF);
    alu_vec("slti",   3'b101, 6'b000000, 5'd0,  32'd3,        32'd5,        4'b0111, 1'b0, 32'd1);
    alu_vec("wrap",   3'b000, 6'b000000, 5'd0,  32'hFFFFFFFF, 32'd1,        4'b0010, 1'b0, 32'd0);

    mem_wr("sw12",    32'd8, 32'd4, 32'hDEADBEEF);
    mem_rd("lw12",    32'd8, 32'd4, 1'b1);
    mem_rd("alias",   32'd8 + MEM_WORDS * 4, 32'd4, 1'b1);
    mem_rd("byteoff", 32'd9, 32'd4, 1'b1);
    mem_rd("rd_off",  32'd8, 32'd4, 1'b0);
    mem_wr("sw16",    32'd16, 32'd0, 32'h0BADF00D);
    mem_rd("lw12b",   32'd8, 32'd4, 1'b1);
    mem_rd("lw16",    32'd0, 32'd16, 1'b1);
    mem_wr("sw20",    32'd20, 32'd0, 32'hCAFEF00D);

    // Asynchronous reset between edges clears memory immediately.
    @(negedge clk);
    alu_op = 3'b000; src_a = 32'd20; src_b = 32'd0; mem_read = 1'b1;
    rst = 1'b1;
    foreach (mdl[i]) mdl[i] = 32'h0;
    push(K_RD, "rst_async", 32'h0);
    drain();
    mem_wr("wr_in_rst", 32'd20, 32'd0, 32'h12345678);
    @(negedge clk);
    rst = 1'b0;
    mem_rd("after_rst20", 32'd20, 32'd0, 1'b1);
    mem_rd("after_rst12", 32'd8, 32'd4, 1'b1);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = $urandom_range(0, 4095) & 32'hFFFF_FFFC;
      d = $urandom;
      mem_wr("rnd_wr", a, 32'd0, d);
      mem_rd("rnd_rd", 32'd0, a, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
